axil_reg_bridge: RTL and testbench

//  AXI4-Lite slave that turns PS (zu9eg M_AXI_HPM) register accesses into the single-cycle

---
 rtl/axil_reg_bridge_pkg.sv | 20 ++
 rtl/axil_reg_bridge_if.sv | 38 +++
 rtl/axil_reg_bridge.sv | 156 +++++++++++++++
 tb/tb_axil_reg_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to strobe register bus bridge.
package axil_reg_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int REG_AW = 16;
    localparam int REG_DW = 64;

    // One register access in flight at a time; the state shows which phase.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite channel bundle between the PS master and the register bridge.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1. A master holds valid and its payload
// stable until that edge; ready may depend on valid.
interface axil_reg_bridge_if #(
    parameter int ADDR_W = 40
);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave issuing single-cycle strobes on the register bus and
// returning AXI responses; reads are captured a fixed latency after the strobe.
module axil_reg_bridge
    import axil_reg_bridge_pkg::*;
#(
    parameter int AXI_ADDR_W = 40,
    parameter int RD_LATENCY = 6,
    parameter int ADDR_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    axil_reg_bridge_if.slave  s,
    output logic              o_reg_wen,
    output logic [REG_AW-1:0] o_reg_waddr,
    output logic [REG_DW-1:0] o_reg_wdata,
    output logic              o_reg_ren,
    output logic [REG_AW-1:0] o_reg_raddr,
    input  logic [REG_DW-1:0] i_reg_rdata,
    output state_t            dbg_state
);

    state_t            state;
    state_t            state_nxt;
    logic              aw_held;
    logic              w_held;
    logic [REG_AW-1:0] aw_addr;
    logic [REG_DW-1:0] w_data;
    logic [7:0]        w_strb;
    logic              ar_err;
    logic              last_rd;
    logic [3:0]        lat_cnt;
    logic [1:0]        bresp_q;
    logic [1:0]        rresp_q;
    logic [REG_DW-1:0] rdata_q;

    logic wr_ready;
    logic rd_ready;
    logic pick_wr;
    logic pick_rd;
    logic wr_ok;
    logic ar_misaligned;

    // Only the low register-bus bits of the AXI address are decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s.awaddr[AXI_ADDR_W-1:REG_AW], s.araddr[AXI_ADDR_W-1:REG_AW]};

    // Round-robin between a fully held write and a presented read; after a
    // read (or reset) a write wins a tie.
    assign wr_ready      = aw_held && w_held;
    assign rd_ready      = s.arvalid;
    assign pick_wr       = wr_ready && (!rd_ready || last_rd);
    assign pick_rd       = rd_ready && !pick_wr;
    assign wr_ok         = (w_strb == 8'hFF) && !((ADDR_CHECK != 0) && (aw_addr[2:0] != 3'd0));
    assign ar_misaligned = (ADDR_CHECK != 0) && (s.araddr[2:0] != 3'd0);

    assign s.awready = !rst && (state == ST_IDLE) && !aw_held;
    assign s.wready  = !rst && (state == ST_IDLE) && !w_held;
    assign s.arready = !rst && (state == ST_IDLE) && pick_rd;
    assign s.bvalid  = (state == ST_WR_RESP);
    assign s.rvalid  = (state == ST_RD_RESP);
    assign s.bresp   = bresp_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;
    assign o_reg_wen = (state == ST_WR_ISSUE) && wr_ok;
    assign o_reg_ren = (state == ST_RD_ISSUE) && !ar_err;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: every access returns through IDLE, which spaces strobes apart.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_wr)      state_nxt = ST_WR_ISSUE;
                else if (pick_rd) state_nxt = ST_RD_ISSUE;
            end
            ST_WR_ISSUE: state_nxt = ST_WR_RESP;
            ST_WR_RESP:  if (s.bready) state_nxt = ST_IDLE;
            ST_RD_ISSUE: state_nxt = ar_err ? ST_RD_RESP : ST_RD_WAIT;
            ST_RD_WAIT:  if (lat_cnt == 4'd0) state_nxt = ST_RD_RESP;
            ST_RD_RESP:  if (s.rready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Write path: independent AW/W holding, bus address/data loaded as the strobe starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            o_reg_waddr <= '0;
            o_reg_wdata <= '0;
            bresp_q     <= AXI_RESP_OKAY;
        end else begin
            if (s.awvalid && s.awready) begin
                aw_held <= 1'b1;
                aw_addr <= s.awaddr[REG_AW-1:0];
            end
            if (s.wvalid && s.wready) begin
                w_held <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (state == ST_IDLE && pick_wr && wr_ok) begin
                o_reg_waddr <= aw_addr;
                o_reg_wdata <= w_data;
            end
            if (state == ST_WR_ISSUE) bresp_q <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            if (state == ST_WR_RESP && s.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read path and arbitration history: strobe, latency countdown, data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd     <= 1'b1;
            ar_err      <= 1'b0;
            o_reg_raddr <= '0;
            lat_cnt     <= '0;
            rresp_q     <= AXI_RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            if (state == ST_IDLE && pick_wr) last_rd <= 1'b0;
            if (state == ST_IDLE && pick_rd) begin
                last_rd <= 1'b1;
                ar_err  <= ar_misaligned;
                if (!ar_misaligned) o_reg_raddr <= s.araddr[REG_AW-1:0];
            end
            if (state == ST_RD_ISSUE) begin
                lat_cnt <= 4'(RD_LATENCY - 1);
                if (ar_err) begin
                    rresp_q <= AXI_RESP_SLVERR;
                    rdata_q <= '0;
                end else begin
                    rresp_q <= AXI_RESP_OKAY;
                end
            end
            if (state == ST_RD_WAIT) begin
                if (lat_cnt == 4'd0) rdata_q <= i_reg_rdata;
                else                 lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Bench for axil_reg_bridge: directed AXI accesses, a register-bus model that
// drives valid read data only at the expected latency, and a scoreboard.
module tb_axil_reg_bridge;
    import axil_reg_bridge_pkg::*;

    localparam int AW = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axil_reg_bridge_if #(.ADDR_W(AW)) bus ();

    logic        o_reg_wen;
    logic [15:0] o_reg_waddr;
    logic [63:0] o_reg_wdata;
    logic        o_reg_ren;
    logic [15:0] o_reg_raddr;
    logic [63:0] i_reg_rdata;
    state_t      dbg_state;

    axil_reg_bridge #(.AXI_ADDR_W(AW), .RD_LATENCY(6), .ADDR_CHECK(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (bus.slave),
        .o_reg_wen   (o_reg_wen),
        .o_reg_waddr (o_reg_waddr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_ren   (o_reg_ren),
        .o_reg_raddr (o_reg_raddr),
        .i_reg_rdata (i_reg_rdata),
        .dbg_state   (dbg_state)
    );

    // ---------------- register bus model ----------------
    int          rd_age = 0;
    logic [15:0] rd_addr_m = '0;

    function automatic logic [63:0] model_val(input logic [15:0] a);
        case (a)
            16'h0038: return 64'h9000_0000_0000_0155;
            16'h0040: return 64'h0123_4567_89AB_CDEF;
            default:  return {48'hA5A5_A5A5_A5A5, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) rd_age <= 0;
        else if (o_reg_ren) begin
            rd_age    <= 1;
            rd_addr_m <= o_reg_raddr;
        end else if (rd_age != 0 && rd_age < 100) rd_age <= rd_age + 1;
    end

    assign i_reg_rdata = (rd_age == 6) ? model_val(rd_addr_m) : {32'hBAD0_BAD0, 32'(rd_age)};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [80:0] exp_stb_q[$];   // {is_write, addr, data}
    logic [1:0]  exp_b_q[$];
    logic [65:0] exp_r_q[$];     // {rresp, rdata}

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int last_stb = -100;
    int wen_cyc = 0;
    int wen_count = 0;
    int stb_count = 0;
    int b_rise_cyc = 0;
    logic bvalid_prev = 1'b0;
    int both_viol = 0;
    int rvalid_cnt = 0;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (o_reg_wen || o_reg_ren) begin
                logic [80:0] act;
                stb_count++;
                chk("strobe_gap", 128'((cyc - last_stb) >= 2), 128'd1);
                last_stb = cyc;
                act = o_reg_wen ? {1'b1, o_reg_waddr, o_reg_wdata} : {1'b0, o_reg_raddr, 64'h0};
                if (o_reg_wen) begin
                    wen_cyc = cyc;
                    wen_count++;
                end
                if (exp_stb_q.size() == 0) chk("unexpected_strobe", 128'(act), 128'd0);
                else chk("strobe", 128'(act), 128'(exp_stb_q.pop_front()));
            end
            if (bus.bvalid && bus.rvalid) both_viol++;
            if (bus.rvalid) rvalid_cnt++;
            if (bus.bvalid && !bvalid_prev) b_rise_cyc = cyc;
            bvalid_prev = bus.bvalid;
            if (bus.bvalid && bus.bready) begin
                if (exp_b_q.size() == 0) chk("unexpected_b", 128'(bus.bresp), 128'h3);
                else chk("bresp", 128'(bus.bresp), 128'(exp_b_q.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r_q.size() == 0) chk("unexpected_r", 128'({bus.rresp, bus.rdata}), 128'h0);
                else chk("rresp_rdata", 128'({bus.rresp, bus.rdata}), 128'(exp_r_q.pop_front()));
            end
        end else begin
            bvalid_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    int w_hs_cyc = 0;

    task automatic drive_aw(input logic [AW-1:0] a);
        bit ok = 0;
        @(negedge clk);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #1;
            if (bus.awready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("aw_timeout", 128'd0, 128'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [63:0] d, input logic [7:0] strb);
        bit ok = 0;
        @(negedge clk);
        bus.wdata  = d;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #1;
            if (bus.wready) begin ok = 1; w_hs_cyc = cyc; break; end
            @(negedge clk);
        end
        if (!ok) chk("w_timeout", 128'd0, 128'd1);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [AW-1:0] a);
        bit ok = 0;
        @(negedge clk);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #1;
            if (bus.arready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("ar_timeout", 128'd0, 128'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #3;
            if (exp_stb_q.size() == 0 && exp_b_q.size() == 0 && exp_r_q.size() == 0 &&
                dbg_state == ST_IDLE && !bus.awvalid && !bus.wvalid && !bus.arvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_idle_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_stb_q.delete();
        exp_b_q.delete();
        exp_r_q.delete();
        @(negedge clk);
        #3;
        chk("reset_ctrl", 128'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                                bus.bresp, bus.rresp, o_reg_wen, o_reg_ren, o_reg_waddr,
                                o_reg_raddr, dbg_state}), 128'd0);
        chk("reset_data", {bus.rdata, o_reg_wdata}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int viol;
        bit seen;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        do_reset();

        // 1: AW first, W three cycles later; strobe and B latency
        wen_count = 0;
        exp_stb_q.push_back({1'b1, 16'h0028, 64'h0000_0000_1234_5678});
        exp_b_q.push_back(AXI_RESP_OKAY);
        fork
            drive_aw(40'h28);
            begin repeat (3) @(negedge clk); drive_w(64'h1234_5678, 8'hFF); end
        join
        wait_idle("t1");
        chk("t1_wen_latency", 128'(wen_cyc - w_hs_cyc), 128'd2);
        chk("t1_bvalid_latency", 128'(b_rise_cyc - w_hs_cyc), 128'd3);
        chk("t1_wen_count", 128'(wen_count), 128'd1);

        // 2: read with data valid only at ren+6
        exp_stb_q.push_back({1'b0, 16'h0038, 64'h0});
        exp_r_q.push_back({AXI_RESP_OKAY, 64'h9000_0000_0000_0155});
        drive_ar(40'h38);
        wait_idle("t2");

        // 3: partial strobe write and misaligned read -> SLVERR, no strobe
        stb_count = 0;
        exp_b_q.push_back(AXI_RESP_SLVERR);
        fork
            drive_aw(40'h30);
            drive_w(64'hCAFE, 8'h0F);
        join
        wait_idle("t3w");
        exp_r_q.push_back({AXI_RESP_SLVERR, 64'h0});
        drive_ar(40'h44);
        wait_idle("t3r");
        chk("t3_no_strobe", 128'(stb_count), 128'd0);

        // 4: simultaneous write and read, twice -> W, R, W, R
        do_reset();
        exp_stb_q.push_back({1'b1, 16'h0100, 64'h1111});
        exp_stb_q.push_back({1'b0, 16'h0040, 64'h0});
        exp_b_q.push_back(AXI_RESP_OKAY);
        exp_r_q.push_back({AXI_RESP_OKAY, 64'h0123_4567_89AB_CDEF});
        fork
            drive_aw(40'h100);
            drive_w(64'h1111, 8'hFF);
            begin @(negedge clk); drive_ar(40'h40); end
        join
        wait_idle("t4a");
        exp_stb_q.push_back({1'b1, 16'h0108, 64'h2222});
        exp_stb_q.push_back({1'b0, 16'h0048, 64'h0});
        exp_b_q.push_back(AXI_RESP_OKAY);
        exp_r_q.push_back({AXI_RESP_OKAY, 64'hA5A5_A5A5_A5A5_0048});
        fork
            drive_aw(40'h108);
            drive_w(64'h2222, 8'hFF);
            begin @(negedge clk); drive_ar(40'h48); end
        join
        wait_idle("t4b");

        // 5: B stalled 20 cycles blocks a pending read
        bus.bready = 1'b0;
        exp_stb_q.push_back({1'b1, 16'h0200, 64'h5555});
        exp_stb_q.push_back({1'b0, 16'h0050, 64'h0});
        exp_b_q.push_back(AXI_RESP_OKAY);
        exp_r_q.push_back({AXI_RESP_OKAY, 64'hA5A5_A5A5_A5A5_0050});
        fork
            drive_aw(40'h200);
            drive_w(64'h5555, 8'hFF);
        join
        fork
            drive_ar(40'h50);
        join_none
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #3;
            if (bus.bvalid) begin seen = 1; break; end
        end
        chk("t5_bvalid_seen", 128'(seen), 128'd1);
        viol = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #3;
            if (bus.arready || o_reg_ren) viol++;
        end
        chk("t5_stall_blocks", 128'(viol), 128'd0);
        @(negedge clk);
        bus.bready = 1'b1;
        wait_idle("t5");

        // 6: reset during RD_WAIT aborts the read silently
        exp_stb_q.push_back({1'b0, 16'h0058, 64'h0});
        drive_ar(40'h58);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            #3;
            if (dbg_state == ST_RD_WAIT) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("t6_reached_rd_wait", 128'(seen), 128'd1);
        do_reset();
        rvalid_cnt = 0;
        repeat (12) @(negedge clk);
        chk("t6_no_rvalid", 128'(rvalid_cnt), 128'd0);
        exp_stb_q.push_back({1'b0, 16'h0038, 64'h0});
        exp_r_q.push_back({AXI_RESP_OKAY, 64'h9000_0000_0000_0155});
        drive_ar(40'h38);
        wait_idle("t6");

        chk("queues_empty", 128'(exp_stb_q.size() + exp_b_q.size() + exp_r_q.size()), 128'd0);
        chk("b_r_exclusive", 128'(both_viol), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
